// File: rtl/gray_pkg.sv
// Shared Gray-code helpers. Functions work on a 32-bit word; callers zero-extend
// narrower values and truncate results, which is exact for any width up to 32.
package gray_pkg;

    localparam int unsigned GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] word_t;

    function automatic word_t bin2gray(input word_t b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero-extended upper bits decode to zero.
    function automatic word_t gray2bin(input word_t g);
        word_t b;
        b = '0;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int unsigned i = GRAY_MAX_W - 1; i > 0; i--) begin
            b[i-1] = b[i] ^ g[i-1];
        end
        return b;
    endfunction

    function automatic logic [5:0] popcount(input word_t w);
        logic [5:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < GRAY_MAX_W; i++) begin
            cnt = cnt + {5'b0, w[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary decoder used for the round-trip self check.
module gray_to_binary
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] b
);

    assign b = WIDTH'(gray2bin(word_t'(g)));

endmodule

// File: rtl/binary_to_gray.sv
// Binary-to-Gray converter with combinational and registered outputs, a
// single-bit-step flag and a sticky round-trip error flag.
module binary_to_gray
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] binary,
    output logic [WIDTH-1:0] gray,
    input  logic             in_valid,
    output logic [WIDTH-1:0] gray_q,
    output logic             out_valid,
    output logic             step_ok,
    output logic             rt_err
);

    logic [WIDTH-1:0] decoded;
    logic             one_step;

    assign gray = WIDTH'(bin2gray(word_t'(binary)));

    gray_to_binary #(.WIDTH(WIDTH)) u_dec (
        .g (gray),
        .b (decoded)
    );

    // Compared against the currently held capture, which is zero after reset.
    assign one_step = (popcount(word_t'(gray ^ gray_q)) == 6'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gray_q    <= '0;
            out_valid <= 1'b0;
            step_ok   <= 1'b0;
            rt_err    <= 1'b0;
        end else if (in_valid) begin
            gray_q    <= gray;
            out_valid <= 1'b1;
            step_ok   <= one_step;
            if (decoded != binary) begin
                rt_err <= 1'b1;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_binary_to_gray.sv
// Directed self-checking bench for binary_to_gray (WIDTH 4 and WIDTH 8 instances).
module tb_binary_to_gray;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] binary;
    logic [3:0] gray;
    logic       in_valid;
    logic [3:0] gray_q;
    logic       out_valid;
    logic       step_ok;
    logic       rt_err;

    logic [7:0] b8;
    logic [7:0] g8;
    logic       v8;
    logic [7:0] gq8;
    logic       ov8;
    logic       so8;
    logic       rt8;

    int unsigned tests  = 0;
    int unsigned failed = 0;

    logic [3:0] exp_gray [16] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
    };

    always #5 clk = ~clk;

    binary_to_gray #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .binary    (binary),
        .gray      (gray),
        .in_valid  (in_valid),
        .gray_q    (gray_q),
        .out_valid (out_valid),
        .step_ok   (step_ok),
        .rt_err    (rt_err)
    );

    binary_to_gray #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .binary    (b8),
        .gray      (g8),
        .in_valid  (v8),
        .gray_q    (gq8),
        .out_valid (ov8),
        .step_ok   (so8),
        .rt_err    (rt8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [3:0] b);
        binary   = b;
        in_valid = 1'b1;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        binary   = '0;
        in_valid = 1'b0;
        b8       = '0;
        v8       = 1'b0;
        tick();
        tick();
        check("rst_gray_q",    32'(gray_q),    32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_step_ok",   32'(step_ok),   32'h0);
        check("rst_rt_err",    32'(rt_err),    32'h0);
        check("rst8_gray_q",   32'(gq8),       32'h0);

        for (int i = 0; i < 16; i++) begin
            binary = 4'(i);
            #5;
            check($sformatf("comb_%0d", i), 32'(gray), 32'(exp_gray[i]));
        end

        rst_n = 1'b1;
        idle();

        // Counting stream 0..15 then wrap to 0.
        for (int i = 0; i <= 16; i++) begin
            capture(4'(i % 16));
            check($sformatf("cnt_q_%0d", i),  32'(gray_q),    32'(exp_gray[i % 16]));
            check($sformatf("cnt_ov_%0d", i), 32'(out_valid), 32'h1);
            check($sformatf("cnt_so_%0d", i), 32'(step_ok),   (i == 0) ? 32'h0 : 32'h1);
            check($sformatf("cnt_rt_%0d", i), 32'(rt_err),    32'h0);
        end
        idle();
        check("cnt_idle_ov", 32'(out_valid), 32'h0);
        check("cnt_idle_q",  32'(gray_q),    32'h0);

        // Gapped valid.
        capture(4'd5);
        check("gap_q5",   32'(gray_q),    32'b0111);
        check("gap_ov5",  32'(out_valid), 32'h1);
        idle();
        check("gap_hold5", 32'(gray_q),    32'b0111);
        check("gap_idle5", 32'(out_valid), 32'h0);
        capture(4'd6);
        check("gap_q6",   32'(gray_q),    32'b0101);
        check("gap_ov6",  32'(out_valid), 32'h1);
        check("gap_so6",  32'(step_ok),   32'h1);
        idle();
        check("gap_hold6", 32'(gray_q),    32'b0101);
        check("gap_idle6", 32'(out_valid), 32'h0);
        check("gap_sohold", 32'(step_ok),  32'h1);

        // Jumps.
        capture(4'd0);
        check("jmp_q0",   32'(gray_q),  32'b0000);
        check("jmp_so0",  32'(step_ok), 32'h0);
        capture(4'd15);
        check("jmp_q15",  32'(gray_q),  32'b1000);
        check("jmp_so15", 32'(step_ok), 32'h1);
        capture(4'd3);
        check("jmp_q3",   32'(gray_q),  32'b0010);
        check("jmp_so3",  32'(step_ok), 32'h0);
        capture(4'd12);
        check("jmp_q12",  32'(gray_q),  32'b1010);
        check("jmp_so12", 32'(step_ok), 32'h1);
        capture(4'd0);
        check("jmp_q0b",  32'(gray_q),  32'b0000);
        capture(4'd2);
        check("jmp_q2",   32'(gray_q),  32'b0011);
        check("jmp_so2",  32'(step_ok), 32'h0);

        // Reset mid-stream with in_valid high.
        capture(4'd10);
        check("mid_q10", 32'(gray_q), 32'b1111);
        rst_n    = 1'b0;
        binary   = 4'd11;
        in_valid = 1'b1;
        tick();
        check("mid_rst_q",  32'(gray_q),    32'h0);
        check("mid_rst_ov", 32'(out_valid), 32'h0);
        check("mid_rst_so", 32'(step_ok),   32'h0);
        check("mid_rst_rt", 32'(rt_err),    32'h0);
        check("mid_comb",   32'(gray),      32'b1110);
        rst_n = 1'b1;
        capture(4'd1);
        check("post_rst_q",  32'(gray_q),  32'b0001);
        check("post_rst_so", 32'(step_ok), 32'h1);
        in_valid = 1'b0;

        // WIDTH = 8 instance.
        b8 = 8'hFF;
        #1;
        check("w8_ff", 32'(g8), 32'h80);
        b8 = 8'hA5;
        #1;
        check("w8_a5", 32'(g8), 32'hF7);
        tick();
        for (int i = 0; i < 256; i++) begin
            b8 = 8'(i);
            v8 = 1'b1;
            tick();
        end
        v8 = 1'b0;
        check("w8_rt_err", 32'(rt8), 32'h0);
        check("w8_last_q", 32'(gq8), 32'h80);
        check("w8_step",   32'(so8), 32'h1);
        check("w8_ov",     32'(ov8), 32'h1);
        tick();
        check("w8_idle_ov", 32'(ov8), 32'h0);
        check("rt_err_end", 32'(rt_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
